// File: rtl/mult3_sched_pkg.sv
// Shared types and residue arithmetic for the mult-of-3 stream scheduler.
package mult3_sched_pkg;

    localparam int RES_W = 2;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        ACK,
        RTZ,
        REPORT,
        FLUSH,
        ERR
    } state_e;

    // Residue after appending bit b to a prefix with residue r: (2r + b) mod 3.
    function automatic logic [RES_W-1:0] next_residue(input logic [RES_W-1:0] r, input logic b);
        logic [RES_W:0] t;
        t = {r, b};
        if (t >= 3'd3) t = t - 3'd3;
        return t[RES_W-1:0];
    endfunction

endpackage

// File: rtl/mult3_ack_sync.sv
// Multi-flop synchroniser for the detector's two asynchronous acknowledge rails.
module mult3_ack_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic parity0,
    input  logic parity1,
    output logic sync0,
    output logic sync1
);

    logic [SYNC_STAGES-1:0][1:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[SYNC_STAGES-2:0], {parity1, parity0}};
    end

    assign sync0 = pipe[SYNC_STAGES-1][0];
    assign sync1 = pipe[SYNC_STAGES-1][1];

endmodule

// File: rtl/mult3_stream_sched.sv
// Arbitrates two requesters onto one async dual-rail mult-of-3 detector, serialises
// words MSB-first with a four-phase handshake and flushes the detector back to residue 0.
module mult3_stream_sched
    import mult3_sched_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] word0,
    input  logic [WIDTH-1:0] word1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             result,
    output logic             result_id,
    output logic             err,
    output logic             mt_in0,
    output logic             mt_in1,
    input  logic             mt_parity0,
    input  logic             mt_parity1
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state, state_d;
    logic [WIDTH-1:0] shreg, flush_pat;
    logic [CW-1:0]    bitcnt;
    logic [RES_W-1:0] res, res_nxt;
    logic [15:0]      tmo;
    logic             rr, gid, last_zero, flushing;
    logic             ack0, ack1, ack_any, tmo_hit, gsel;

    mult3_ack_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk     (clk),
        .rst     (rst),
        .parity0 (mt_parity0),
        .parity1 (mt_parity1),
        .sync0   (ack0),
        .sync1   (ack1)
    );

    assign ack_any   = ack0 | ack1;
    assign tmo_hit   = (tmo == 16'(TIMEOUT - 1));
    assign res_nxt   = next_residue(res, shreg[WIDTH-1]);
    assign gsel      = (req == 2'b11) ? rr : req[1];
    assign busy      = (state != IDLE);
    assign result    = last_zero;
    assign result_id = gid;

    // Flush bits that walk the residue back to 0: r=1 -> "1", r=2 -> "0","1".
    always_comb begin
        flush_pat          = '0;
        flush_pat[WIDTH-1] = (res == 2'd1);
        flush_pat[WIDTH-2] = (res == 2'd2);
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (|req) state_d = SEND;
            SEND:   state_d = ACK;
            ACK: begin
                if (ack_any)      state_d = (ack1 != (res_nxt == '0)) ? ERR : RTZ;
                else if (tmo_hit) state_d = ERR;
            end
            RTZ: begin
                if (!ack_any) begin
                    if (bitcnt != CW'(1)) state_d = SEND;
                    else                  state_d = flushing ? IDLE : REPORT;
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            REPORT: state_d = (res == '0) ? IDLE : FLUSH;
            FLUSH:  state_d = SEND;
            ERR:    state_d = ERR;
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bitcnt    <= '0;
            res       <= '0;
            tmo       <= '0;
            rr        <= 1'b0;
            gid       <= 1'b0;
            last_zero <= 1'b0;
            flushing  <= 1'b0;
            gnt       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            mt_in0    <= 1'b0;
            mt_in1    <= 1'b0;
        end else begin
            state <= state_d;
            gnt   <= '0;
            done  <= (state_d == REPORT);
            // Phase timer restarts on every state change and saturates otherwise.
            if (state_d != state) tmo <= '0;
            else if (tmo != '1)   tmo <= tmo + 16'd1;
            if (state_d == ERR) err <= 1'b1;

            case (state)
                IDLE: if (|req) begin
                    gnt      <= gsel ? 2'b10 : 2'b01;
                    gid      <= gsel;
                    shreg    <= gsel ? word1 : word0;
                    bitcnt   <= CW'(WIDTH);
                    flushing <= 1'b0;
                    if (&req) rr <= ~rr;
                end
                SEND: begin
                    mt_in1 <= shreg[WIDTH-1];
                    mt_in0 <= ~shreg[WIDTH-1];
                end
                ACK: if (ack_any) begin
                    last_zero <= ack1;
                    res       <= res_nxt;
                    shreg     <= shreg << 1;
                    mt_in0    <= 1'b0;
                    mt_in1    <= 1'b0;
                end
                RTZ: if (!ack_any) bitcnt <= bitcnt - CW'(1);
                FLUSH: begin
                    flushing <= 1'b1;
                    shreg    <= flush_pat;
                    bitcnt   <= (res == 2'd1) ? CW'(1) : CW'(2);
                end
                default: ;
            endcase

            if (state_d == ERR) begin
                mt_in0 <= 1'b0;
                mt_in1 <= 1'b0;
            end
        end
    end

endmodule
